// File: rtl/alu_shift_mem_unit.sv
// ALU, barrel shifter and 256x8 data memory with registered carry and zero flags.
// Build option: define MEM_RESET_CLEAR_EN to clear the memory asynchronously while reset is low.
module alu_shift_mem_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] alu_op,
    input  logic       alu_use_carry,
    input  logic [2:0] sh_count,
    input  logic       sh_dir,
    input  logic       sh_roBar,
    input  logic       mem_write,
    input  logic [1:0] res_sel,
    input  logic       select_c,
    input  logic       select_z,
    input  logic       write_c,
    input  logic       write_z,
    output logic [7:0] result,
    output logic [7:0] alu_out,
    output logic [7:0] mem_rdata,
    output logic       C,
    output logic       Z
);

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_AND    = 3'b010,
        OP_OR     = 3'b011,
        OP_XOR    = 3'b100,
        OP_NOT    = 3'b101,
        OP_PASS_B = 3'b110,
        OP_PASS_A = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU   = 2'b00,
        RES_SHIFT = 2'b01,
        RES_MEM   = 2'b10,
        RES_ZERO  = 2'b11
    } res_sel_e;

    alu_op_e    op;
    res_sel_e   sel;
    logic       cin;
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic       alu_co;
    logic       alu_z;
    logic [15:0] shl;
    logic [15:0] shr;
    logic [7:0] sh_out;
    logic       sh_co;
    logic       sh_z;
    logic [7:0] mem [256];

    assign op  = alu_op_e'(alu_op);
    assign sel = res_sel_e'(res_sel);

    // Carry-in comes from the flag register only, so no combinational loop through C.
    assign cin   = alu_use_carry & C;
    assign sum9  = {1'b0, a} + {1'b0, b} + {8'h00, cin};
    assign diff9 = {1'b0, a} - {1'b0, b} - {8'h00, cin};

    always_comb begin
        alu_out = '0;
        alu_co  = 1'b0;
        case (op)
            OP_ADD: begin
                alu_out = sum9[7:0];
                alu_co  = sum9[8];
            end
            OP_SUB: begin
                alu_out = diff9[7:0];
                alu_co  = diff9[8];
            end
            OP_AND:    alu_out = a & b;
            OP_OR:     alu_out = a | b;
            OP_XOR:    alu_out = a ^ b;
            OP_NOT:    alu_out = ~a;
            OP_PASS_B: alu_out = b;
            OP_PASS_A: alu_out = a;
        endcase
    end

    assign alu_z = (alu_out == 8'h00);

    // Widened shifts: the byte beside the data holds the shifted-out bits, which
    // give both the rotate wrap-around and the last bit out (zero when count is 0).
    assign shl = {8'h00, a} << sh_count;
    assign shr = {a, 8'h00} >> sh_count;

    always_comb begin
        sh_out = a;
        sh_co  = 1'b0;
        if (sh_count != 3'd0) begin
            if (!sh_dir) begin
                if (sh_roBar) begin
                    sh_out = shl[7:0];
                    sh_co  = shl[8];
                end else begin
                    sh_out = shl[7:0] | shl[15:8];
                    sh_co  = shl[8];
                end
            end else begin
                if (sh_roBar) begin
                    sh_out = shr[15:8];
                    sh_co  = shr[7];
                end else begin
                    sh_out = shr[15:8] | shr[7:0];
                    sh_co  = shr[7];
                end
            end
        end
    end

    assign sh_z = (sh_out == 8'h00);

    assign mem_rdata = mem[alu_out];

`ifdef MEM_RESET_CLEAR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 256; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_write) begin
            mem[alu_out] <= b;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset && mem_write) begin
            mem[alu_out] <= b;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            C <= 1'b0;
            Z <= 1'b0;
        end else begin
            if (write_c) C <= select_c ? sh_co : alu_co;
            if (write_z) Z <= select_z ? sh_z : alu_z;
        end
    end

    always_comb begin
        result = '0;
        case (sel)
            RES_ALU:   result = alu_out;
            RES_SHIFT: result = sh_out;
            RES_MEM:   result = mem_rdata;
            RES_ZERO:  result = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_shift_mem_unit.sv
// Directed self-checking bench for alu_shift_mem_unit (ALU, shifter, memory, flags, reset).
module tb_alu_shift_mem_unit;

    logic       clk;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] alu_op;
    logic       alu_use_carry;
    logic [2:0] sh_count;
    logic       sh_dir;
    logic       sh_roBar;
    logic       mem_write;
    logic [1:0] res_sel;
    logic       select_c;
    logic       select_z;
    logic       write_c;
    logic       write_z;
    logic [7:0] result;
    logic [7:0] alu_out;
    logic [7:0] mem_rdata;
    logic       C;
    logic       Z;

    int checks = 0;
    int errors = 0;

    alu_shift_mem_unit dut (
        .clk          (clk),
        .reset        (reset),
        .a            (a),
        .b            (b),
        .alu_op       (alu_op),
        .alu_use_carry(alu_use_carry),
        .sh_count     (sh_count),
        .sh_dir       (sh_dir),
        .sh_roBar     (sh_roBar),
        .mem_write    (mem_write),
        .res_sel      (res_sel),
        .select_c     (select_c),
        .select_z     (select_z),
        .write_c      (write_c),
        .write_z      (write_z),
        .result       (result),
        .alu_out      (alu_out),
        .mem_rdata    (mem_rdata),
        .C            (C),
        .Z            (Z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [2:0] n;
        logic       dir;
        logic       ro;
        logic [7:0] r;
        logic       c;
        logic       z;
    } sh_vec_t;

    sh_vec_t    sv [12];
    logic [7:0] logic_exp [6];

    initial begin
        sv[0]  = '{8'h81, 3'd1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
        sv[1]  = '{8'h81, 3'd0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        sv[2]  = '{8'h81, 3'd1, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0};
        sv[3]  = '{8'h81, 3'd3, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0};
        sv[4]  = '{8'h01, 3'd1, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};
        sv[5]  = '{8'h02, 3'd1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        sv[6]  = '{8'h80, 3'd1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
        sv[7]  = '{8'h81, 3'd0, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0};
        sv[8]  = '{8'hC5, 3'd7, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        sv[9]  = '{8'hC5, 3'd4, 1'b0, 1'b0, 8'h5C, 1'b0, 1'b0};
        sv[10] = '{8'h0F, 3'd5, 1'b0, 1'b1, 8'hE0, 1'b1, 1'b0};
        sv[11] = '{8'h00, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        logic_exp[0] = 8'h42;
        logic_exp[1] = 8'hDB;
        logic_exp[2] = 8'h99;
        logic_exp[3] = 8'h3C;
        logic_exp[4] = 8'h5A;
        logic_exp[5] = 8'hC3;

        a = '0; b = '0; alu_op = 3'b000; alu_use_carry = 1'b0;
        sh_count = '0; sh_dir = 1'b0; sh_roBar = 1'b1; mem_write = 1'b0;
        res_sel = 2'b11; select_c = 1'b0; select_z = 1'b0;
        write_c = 1'b0; write_z = 1'b0;
        reset = 1'b1;

        #2 reset = 1'b0;
        #1;
        check("rst_c", {7'b0, C}, 8'h00);
        check("rst_z", {7'b0, Z}, 8'h00);
        a = 8'h12; b = 8'h34; res_sel = 2'b00;
        #1 check("rst_comb_add", result, 8'h46);

        a = 8'hFF; b = 8'h01; write_c = 1'b1; write_z = 1'b1;
        tick();
        check("rst_hold_c", {7'b0, C}, 8'h00);
        check("rst_hold_z", {7'b0, Z}, 8'h00);

        @(negedge clk) reset = 1'b1;
        #1 check("add_ff_01", alu_out, 8'h00);
        tick();
        check("add_c", {7'b0, C}, 8'h01);
        check("add_z", {7'b0, Z}, 8'h01);

        a = 8'h10; b = 8'h20; alu_op = 3'b001;
        #1 check("sub_10_20", alu_out, 8'hF0);
        tick();
        check("sub_borrow", {7'b0, C}, 8'h01);
        check("sub_z", {7'b0, Z}, 8'h00);

        alu_use_carry = 1'b1; a = 8'h05; b = 8'h01; alu_op = 3'b000;
        #1 check("adc_chain", alu_out, 8'h07);
        tick();
        check("adc_c", {7'b0, C}, 8'h00);

        a = 8'h00; b = 8'h01; alu_op = 3'b001;
        #1 check("sbb_wrap", alu_out, 8'hFF);
        tick();
        check("sbb_wrap_c", {7'b0, C}, 8'h01);
        a = 8'h05; b = 8'h04;
        #1 check("sbb_cin", alu_out, 8'h00);
        tick();
        check("sbb_cin_c", {7'b0, C}, 8'h00);
        check("sbb_cin_z", {7'b0, Z}, 8'h01);

        alu_use_carry = 1'b0; a = 8'hFF; b = 8'h01; alu_op = 3'b000;
        tick();
        a = 8'hC3; b = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            alu_op = 3'(i + 2);
            #1 check($sformatf("logic_op%0d", i + 2), alu_out, logic_exp[i]);
        end
        alu_op = 3'b010;
        tick();
        check("logic_c0", {7'b0, C}, 8'h00);
        check("logic_z0", {7'b0, Z}, 8'h00);

        write_c = 1'b0; write_z = 1'b0; a = 8'hFF; b = 8'h01; alu_op = 3'b000;
        tick();
        check("hold_c", {7'b0, C}, 8'h00);
        check("hold_z", {7'b0, Z}, 8'h00);

        write_c = 1'b1; write_z = 1'b1; select_c = 1'b1; select_z = 1'b1; res_sel = 2'b01;
        for (int i = 0; i < 12; i++) begin
            a = sv[i].a; sh_count = sv[i].n; sh_dir = sv[i].dir; sh_roBar = sv[i].ro;
            #1 check($sformatf("sh%0d_res", i), result, sv[i].r);
            tick();
            check($sformatf("sh%0d_c", i), {7'b0, C}, {7'b0, sv[i].c});
            check($sformatf("sh%0d_z", i), {7'b0, Z}, {7'b0, sv[i].z});
        end

        select_c = 1'b0; select_z = 1'b0; write_c = 1'b0; write_z = 1'b0;
        res_sel = 2'b10; alu_op = 3'b110; b = 8'h5A; mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        #1 check("mem_rd_5a", result, 8'h5A);
        alu_op = 3'b111; a = 8'h5A; b = 8'h33; mem_write = 1'b1;
        #1 check("mem_rdw_old", mem_rdata, 8'h5A);
        tick();
        check("mem_rdw_new", mem_rdata, 8'h33);
        a = 8'hA5; b = 8'hC3;
        tick();
        mem_write = 1'b0; a = 8'h5A;
        #1 check("mem_addr_5a", mem_rdata, 8'h33);
        a = 8'hA5;
        #1 check("mem_addr_a5", result, 8'hC3);
        res_sel = 2'b11;
        #1 check("res_zero", result, 8'h00);

        alu_op = 3'b000; a = 8'hFF; b = 8'h01; write_c = 1'b1; write_z = 1'b1;
        tick();
        check("pre_rst_c", {7'b0, C}, 8'h01);
        check("pre_rst_z", {7'b0, Z}, 8'h01);
        alu_op = 3'b111; a = 8'h5A; b = 8'h77; mem_write = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("async_rst_c", {7'b0, C}, 8'h00);
        check("async_rst_z", {7'b0, Z}, 8'h00);
        tick();
        check("rst_block_c", {7'b0, C}, 8'h00);
        @(negedge clk) reset = 1'b1;
        mem_write = 1'b0;
`ifdef MEM_RESET_CLEAR_EN
        #1 check("mem_after_rst", mem_rdata, 8'h00);
`else
        #1 check("mem_after_rst", mem_rdata, 8'h33);
`endif
        alu_op = 3'b000; a = 8'hFF; b = 8'h01;
        tick();
        check("post_rst_c", {7'b0, C}, 8'h01);
        check("post_rst_z", {7'b0, Z}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
